// File: rtl/id_stage_hazard.sv
// Decode-stage pipeline shell: IF->ID register, regfile read steering,
// RAW hazard resolution (forward or interlock), branch cancel and stall counting.
module id_stage_hazard #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FWD_EN       = 1,
    parameter int unsigned MEM_LOAD_FWD = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_to_id_valid,
    output logic                 id_allow_in,
    input  logic [XLEN+32-1:0]   if_to_id_bus,
    output logic [XLEN-1:0]      id_pc,
    output logic [31:0]          id_inst,
    input  logic                 dec_rs1_en,
    input  logic                 dec_rs2_en,
    input  logic                 dec_rs2_is_rd,
    output logic [4:0]           rf_raddr1,
    output logic [4:0]           rf_raddr2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    output logic [XLEN-1:0]      rs1_value,
    output logic [XLEN-1:0]      rs2_value,
    input  logic                 exe_valid,
    input  logic                 exe_gr_we,
    input  logic                 exe_res_from_mem,
    input  logic [4:0]           exe_dest,
    input  logic [XLEN-1:0]      exe_result,
    input  logic                 mem_valid,
    input  logic                 mem_gr_we,
    input  logic                 mem_res_from_mem,
    input  logic [4:0]           mem_dest,
    input  logic [XLEN-1:0]      mem_result,
    input  logic                 wb_valid,
    input  logic                 wb_gr_we,
    input  logic [4:0]           wb_dest,
    input  logic [XLEN-1:0]      wb_wdata,
    input  logic                 br_taken,
    output logic                 br_cancel,
    input  logic                 exe_allow_in,
    output logic                 id_ready_go,
    output logic                 id_to_exe_valid,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int unsigned BUS_W = XLEN + 32;
    localparam int unsigned RES_W = XLEN + 1;

    logic             id_valid;
    logic [BUS_W-1:0] id_bus_r;
    logic [4:0]       src1;
    logic [4:0]       src2;
    logic [RES_W-1:0] res1;
    logic [RES_W-1:0] res2;
    logic             stall;

    assign id_pc   = id_bus_r[BUS_W-1:32];
    assign id_inst = id_bus_r[31:0];

    assign src1      = id_inst[9:5];
    assign src2      = dec_rs2_is_rd ? id_inst[4:0] : id_inst[14:10];
    assign rf_raddr1 = src1;
    assign rf_raddr2 = src2;

    function automatic logic hit(input logic v, input logic we, input logic [4:0] dest,
                                 input logic [4:0] src, input logic en);
        return v & we & (dest == src) & (src != 5'd0) & en;
    endfunction

    // Returns {stall, value}; the youngest matching stage shadows all older ones.
    function automatic logic [RES_W-1:0] resolve(input logic [4:0] src, input logic en,
                                                 input logic [XLEN-1:0] rf);
        logic e_hit;
        logic m_hit;
        logic w_hit;
        logic [RES_W-1:0] r;
        e_hit = hit(exe_valid, exe_gr_we, exe_dest, src, en);
        m_hit = hit(mem_valid, mem_gr_we, mem_dest, src, en);
        w_hit = hit(wb_valid, wb_gr_we, wb_dest, src, en);
        r     = {1'b0, rf};
        if (FWD_EN != 0) begin
            if (e_hit)
                r = {exe_res_from_mem, exe_result};
            else if (m_hit)
                r = {mem_res_from_mem & (MEM_LOAD_FWD == 0), mem_result};
            else if (w_hit)
                r = {1'b0, wb_wdata};
        end else begin
            r = {e_hit | m_hit | w_hit, rf};
        end
        return r;
    endfunction

    always_comb begin
        res1 = resolve(src1, dec_rs1_en, rf_rdata1);
        res2 = resolve(src2, dec_rs2_en, rf_rdata2);
    end

    assign rs1_value = res1[XLEN-1:0];
    assign rs2_value = res2[XLEN-1:0];
    assign stall     = res1[XLEN] | res2[XLEN];

    // Handshake; a pending hazard also holds back the branch cancel.
    assign id_ready_go     = ~(id_valid & stall);
    assign id_to_exe_valid = id_valid & id_ready_go;
    assign id_allow_in     = ~id_valid | (id_ready_go & exe_allow_in);
    assign br_cancel       = id_valid & br_taken & id_ready_go & exe_allow_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            id_valid <= 1'b0;
        else if (br_cancel)
            id_valid <= 1'b0;
        else if (id_allow_in)
            id_valid <= if_to_id_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            id_bus_r <= '0;
        else if (if_to_id_valid & id_allow_in & ~br_cancel)
            id_bus_r <= if_to_id_bus;
    end

    // Counts hazard stalls only; EXE backpressure is not a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (id_valid & ~id_ready_go & ~(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_id_stage_hazard.sv
// Scoreboard bench for id_stage_hazard: a forwarding instance (defaults) and an
// interlock instance (FWD_EN=0, CNT_W=4) driven from the same stimulus.
module tb_id_stage_hazard;

    localparam logic [31:0] ADD_R1R2 = 32'h0010_0823;
    localparam logic [31:0] ADD_R0R2 = 32'h0010_0803;
    localparam logic [31:0] BEQ_R1R2 = 32'h5800_0022;

    logic        clk = 1'b0;
    logic        reset, reset_ilk;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_bus;
    logic        dec_rs1_en, dec_rs2_en, dec_rs2_is_rd;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        exe_valid, exe_gr_we, exe_res_from_mem;
    logic [4:0]  exe_dest;
    logic [31:0] exe_result;
    logic        mem_valid, mem_gr_we, mem_res_from_mem;
    logic [4:0]  mem_dest;
    logic [31:0] mem_result;
    logic        wb_valid, wb_gr_we;
    logic [4:0]  wb_dest;
    logic [31:0] wb_wdata;
    logic        br_taken, exe_allow_in;

    logic        id_allow_in, br_cancel, id_ready_go, id_to_exe_valid;
    logic [31:0] id_pc, id_inst, rs1_value, rs2_value;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [15:0] stall_cnt;

    logic        ilk_allow_in, ilk_br_cancel, ilk_ready_go, ilk_to_exe_valid;
    logic [31:0] ilk_pc, ilk_inst, ilk_rs1, ilk_rs2;
    logic [4:0]  ilk_raddr1, ilk_raddr2;
    logic [3:0]  ilk_stall_cnt;

    always #5 clk = ~clk;

    id_stage_hazard u_dut (
        .clk(clk), .reset(reset), .if_to_id_valid(if_to_id_valid), .id_allow_in(id_allow_in),
        .if_to_id_bus(if_to_id_bus), .id_pc(id_pc), .id_inst(id_inst),
        .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en), .dec_rs2_is_rd(dec_rs2_is_rd),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .exe_valid(exe_valid), .exe_gr_we(exe_gr_we), .exe_res_from_mem(exe_res_from_mem),
        .exe_dest(exe_dest), .exe_result(exe_result),
        .mem_valid(mem_valid), .mem_gr_we(mem_gr_we), .mem_res_from_mem(mem_res_from_mem),
        .mem_dest(mem_dest), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_gr_we(wb_gr_we), .wb_dest(wb_dest), .wb_wdata(wb_wdata),
        .br_taken(br_taken), .br_cancel(br_cancel), .exe_allow_in(exe_allow_in),
        .id_ready_go(id_ready_go), .id_to_exe_valid(id_to_exe_valid), .stall_cnt(stall_cnt)
    );

    id_stage_hazard #(.XLEN(32), .FWD_EN(0), .MEM_LOAD_FWD(1), .CNT_W(4)) u_ilk (
        .clk(clk), .reset(reset_ilk), .if_to_id_valid(if_to_id_valid), .id_allow_in(ilk_allow_in),
        .if_to_id_bus(if_to_id_bus), .id_pc(ilk_pc), .id_inst(ilk_inst),
        .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en), .dec_rs2_is_rd(dec_rs2_is_rd),
        .rf_raddr1(ilk_raddr1), .rf_raddr2(ilk_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rs1_value(ilk_rs1), .rs2_value(ilk_rs2),
        .exe_valid(exe_valid), .exe_gr_we(exe_gr_we), .exe_res_from_mem(exe_res_from_mem),
        .exe_dest(exe_dest), .exe_result(exe_result),
        .mem_valid(mem_valid), .mem_gr_we(mem_gr_we), .mem_res_from_mem(mem_res_from_mem),
        .mem_dest(mem_dest), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_gr_we(wb_gr_we), .wb_dest(wb_dest), .wb_wdata(wb_wdata),
        .br_taken(br_taken), .br_cancel(ilk_br_cancel), .exe_allow_in(exe_allow_in),
        .id_ready_go(ilk_ready_go), .id_to_exe_valid(ilk_to_exe_valid), .stall_cnt(ilk_stall_cnt)
    );

    typedef enum int {
        S_ALLOW, S_CANCEL, S_READY, S_TOEXE, S_PC, S_INST, S_RA1, S_RA2, S_RS1, S_RS2, S_CNT,
        S_I_READY, S_I_TOEXE, S_I_RS1, S_I_RS2, S_I_CNT
    } sig_e;

    typedef struct {
        sig_e        sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            S_ALLOW:   return 32'(id_allow_in);
            S_CANCEL:  return 32'(br_cancel);
            S_READY:   return 32'(id_ready_go);
            S_TOEXE:   return 32'(id_to_exe_valid);
            S_PC:      return id_pc;
            S_INST:    return id_inst;
            S_RA1:     return 32'(rf_raddr1);
            S_RA2:     return 32'(rf_raddr2);
            S_RS1:     return rs1_value;
            S_RS2:     return rs2_value;
            S_CNT:     return 32'(stall_cnt);
            S_I_READY: return 32'(ilk_ready_go);
            S_I_TOEXE: return 32'(ilk_to_exe_valid);
            S_I_RS1:   return ilk_rs1;
            S_I_RS2:   return ilk_rs2;
            S_I_CNT:   return 32'(ilk_stall_cnt);
            default:   return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: drains every pending expectation against the live outputs.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = q.pop_front();
            act = sample(e.sig);
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic chk(input sig_e s, input logic [31:0] v, input string n);
        q.push_back('{s, v, n});
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_prod();
        exe_valid = 0; exe_gr_we = 0; exe_res_from_mem = 0; exe_dest = 0; exe_result = 0;
        mem_valid = 0; mem_gr_we = 0; mem_res_from_mem = 0; mem_dest = 0; mem_result = 0;
        wb_valid = 0; wb_gr_we = 0; wb_dest = 0; wb_wdata = 0;
    endtask

    task automatic set_exe(input logic [4:0] d, input logic ld, input logic [31:0] r);
        exe_valid = 1; exe_gr_we = 1; exe_dest = d; exe_res_from_mem = ld; exe_result = r;
    endtask

    task automatic set_mem(input logic [4:0] d, input logic ld, input logic [31:0] r);
        mem_valid = 1; mem_gr_we = 1; mem_dest = d; mem_res_from_mem = ld; mem_result = r;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        if_to_id_valid = 1;
        if_to_id_bus   = {pc, inst};
    endtask

    initial begin
        reset = 1; reset_ilk = 1;
        if_to_id_valid = 0; if_to_id_bus = '0;
        dec_rs1_en = 1; dec_rs2_en = 1; dec_rs2_is_rd = 0;
        rf_rdata1 = 0; rf_rdata2 = 0;
        br_taken = 0; exe_allow_in = 1;
        clr_prod();

        // Reset state
        next_cyc();
        chk(S_TOEXE, 0, "rst_to_exe"); chk(S_ALLOW, 1, "rst_allow"); chk(S_CANCEL, 0, "rst_cancel");
        chk(S_CNT, 0, "rst_cnt"); chk(S_PC, 0, "rst_pc"); chk(S_INST, 0, "rst_inst");
        settle();
        reset = 0; reset_ilk = 0;

        // 1: first instruction handed to ID
        next_cyc();
        fetch(32'h1c00_0000, ADD_R1R2);
        next_cyc();
        if_to_id_valid = 0; exe_allow_in = 0;
        chk(S_TOEXE, 1, "t1_to_exe"); chk(S_PC, 32'h1c00_0000, "t1_pc"); chk(S_INST, ADD_R1R2, "t1_inst");
        chk(S_CNT, 0, "t1_cnt"); chk(S_RA1, 1, "t1_raddr1"); chk(S_RA2, 2, "t1_raddr2");
        chk(S_ALLOW, 0, "t1_backpressure");
        settle();

        // 2: forwarding priority EXE > MEM > WB > regfile
        next_cyc();
        set_exe(1, 0, 32'h11); set_mem(1, 0, 32'h22); rf_rdata1 = 32'h33;
        chk(S_RS1, 32'h11, "t2_exe_fwd"); chk(S_READY, 1, "t2_ready");
        chk(S_I_RS1, 32'h33, "t2_ilk_rf"); chk(S_I_READY, 0, "t2_ilk_stall");
        settle();
        next_cyc();
        exe_dest = 5;
        chk(S_RS1, 32'h22, "t2_mem_fwd"); chk(S_CNT, 0, "t2_cnt_no_bp");
        settle();
        next_cyc();
        mem_valid = 0; wb_valid = 1; wb_gr_we = 1; wb_dest = 1; wb_wdata = 32'h44; dec_rs2_is_rd = 1;
        chk(S_RS1, 32'h44, "t2_wb_fwd"); chk(S_RA2, 3, "t2_raddr2_rd");
        settle();
        next_cyc();
        clr_prod(); dec_rs2_is_rd = 0; rf_rdata2 = 32'h66;
        chk(S_RS1, 32'h33, "t2_rf"); chk(S_RS2, 32'h66, "t2_rf2"); chk(S_CNT, 0, "t2_cnt_hold");
        settle();

        // 3: load-use stall then MEM load forwarding
        next_cyc();
        exe_allow_in = 1; set_exe(1, 1, 32'hbad);
        chk(S_READY, 0, "t3_ld_stall"); chk(S_ALLOW, 0, "t3_allow"); chk(S_TOEXE, 0, "t3_to_exe");
        settle();
        next_cyc();
        clr_prod(); set_mem(1, 1, 32'h55);
        chk(S_READY, 1, "t3_ready"); chk(S_RS1, 32'h55, "t3_mem_ld_fwd"); chk(S_CNT, 1, "t3_cnt");
        chk(S_TOEXE, 1, "t3_to_exe2");
        settle();

        // 5: branch cancel drops the concurrent fetch
        next_cyc();
        clr_prod(); dec_rs2_is_rd = 1; fetch(32'h1c00_0010, BEQ_R1R2);
        next_cyc();
        fetch(32'h1c00_0014, ADD_R1R2); br_taken = 1;
        chk(S_CANCEL, 1, "t5_cancel"); chk(S_TOEXE, 1, "t5_to_exe"); chk(S_PC, 32'h1c00_0010, "t5_pc");
        chk(S_RA2, 2, "t5_raddr2");
        settle();
        next_cyc();
        if_to_id_valid = 0; br_taken = 0;
        chk(S_CANCEL, 0, "t5_cancel_off"); chk(S_TOEXE, 0, "t5_flushed");
        chk(S_INST, BEQ_R1R2, "t5_not_captured"); chk(S_ALLOW, 1, "t5_allow");
        settle();
        // branch under a hazard waits for the operand
        next_cyc();
        fetch(32'h1c00_0018, BEQ_R1R2);
        next_cyc();
        fetch(32'h1c00_001c, ADD_R1R2); br_taken = 1; set_exe(1, 1, 32'hbad);
        chk(S_CANCEL, 0, "t5_cancel_stalled"); chk(S_READY, 0, "t5_stall"); chk(S_ALLOW, 0, "t5_allow_stall");
        chk(S_CNT, 1, "t5_cnt_pre");
        settle();
        next_cyc();
        clr_prod(); set_mem(1, 1, 32'hab);
        chk(S_CANCEL, 1, "t5_cancel_late"); chk(S_RS1, 32'hab, "t5_rs1"); chk(S_CNT, 2, "t5_cnt");
        chk(S_PC, 32'h1c00_0018, "t5_pc_held");
        settle();
        next_cyc();
        if_to_id_valid = 0; br_taken = 0; clr_prod();
        chk(S_TOEXE, 0, "t5_flushed2"); chk(S_PC, 32'h1c00_0018, "t5_pc_drop");
        settle();

        // 4: interlock instance waits for the producer to leave WB
        next_cyc();
        dec_rs2_is_rd = 0; reset_ilk = 1;
        chk(S_I_CNT, 0, "t4_ilk_rst");
        settle();
        reset_ilk = 0;
        next_cyc();
        fetch(32'h1c00_0020, ADD_R1R2);
        next_cyc();
        if_to_id_valid = 0; exe_allow_in = 0; set_exe(2, 0, 32'h77); rf_rdata2 = 32'h99;
        chk(S_I_READY, 0, "t4_stall_exe"); chk(S_I_TOEXE, 0, "t4_to_exe"); chk(S_RS2, 32'h77, "t4_fwd_exe");
        settle();
        next_cyc();
        clr_prod(); set_mem(2, 0, 32'h77);
        chk(S_I_READY, 0, "t4_stall_mem"); chk(S_I_CNT, 1, "t4_cnt1");
        settle();
        next_cyc();
        clr_prod(); wb_valid = 1; wb_gr_we = 1; wb_dest = 2; wb_wdata = 32'h77;
        chk(S_I_READY, 0, "t4_stall_wb"); chk(S_I_CNT, 2, "t4_cnt2"); chk(S_RS2, 32'h77, "t4_fwd_wb");
        settle();
        next_cyc();
        clr_prod();
        chk(S_I_READY, 1, "t4_ready"); chk(S_I_CNT, 3, "t4_cnt3"); chk(S_I_RS2, 32'h99, "t4_rf2");
        chk(S_I_TOEXE, 1, "t4_to_exe_ok"); chk(S_RS2, 32'h99, "t4_main_rf2");
        settle();

        // 6: r0 never hazards
        next_cyc();
        exe_allow_in = 1;
        next_cyc();
        fetch(32'h1c00_0030, ADD_R0R2);
        next_cyc();
        if_to_id_valid = 0; exe_allow_in = 0; set_exe(0, 1, 32'h5a); rf_rdata1 = 0;
        chk(S_READY, 1, "t6_r0_ready"); chk(S_RS1, 0, "t6_r0_rf"); chk(S_I_READY, 1, "t6_ilk_r0");
        chk(S_CNT, 2, "t6_cnt");
        settle();
        // reset in the middle of a stall
        next_cyc();
        set_exe(2, 1, 32'h5a);
        chk(S_READY, 0, "t6_stall");
        settle();
        next_cyc();
        reset = 1; reset_ilk = 1;
        chk(S_TOEXE, 0, "t6_rst_to_exe"); chk(S_ALLOW, 1, "t6_rst_allow"); chk(S_READY, 1, "t6_rst_ready");
        chk(S_CANCEL, 0, "t6_rst_cancel"); chk(S_CNT, 0, "t6_rst_cnt"); chk(S_PC, 0, "t6_rst_pc");
        chk(S_INST, 0, "t6_rst_inst"); chk(S_I_CNT, 0, "t6_rst_ilk_cnt");
        settle();
        reset = 0; reset_ilk = 0;
        // long stall saturates the 4-bit interlock counter
        next_cyc();
        fetch(32'h1c00_0040, ADD_R1R2);
        next_cyc();
        if_to_id_valid = 0;
        chk(S_CNT, 0, "t6_cnt0"); chk(S_READY, 0, "t6_long_stall");
        settle();
        repeat (21) @(posedge clk);
        #1;
        chk(S_I_CNT, 15, "t6_ilk_sat"); chk(S_CNT, 21, "t6_cnt21");
        chk(S_PC, 32'h1c00_0040, "t6_pc_held"); chk(S_TOEXE, 0, "t6_held");
        settle();

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: pending=%0d expected 0", q.size());
            $fatal(1, "scoreboard did not drain");
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
